// File: rtl/sample_queue_if.sv
// Handshake bundle between a sample producer/consumer and the sample_queue FIFO.
// The producer/consumer side uses the master modport; the queue uses the slave modport.
interface sample_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              deq_en;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   len_out;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output in_valid, in_data, deq_en,
        input  out_valid, out_data, len_out, full, empty, overflow
    );

    modport slave (
        input  in_valid, in_data, deq_en,
        output out_valid, out_data, len_out, full, empty, overflow
    );
endinterface

// File: rtl/sample_queue.sv
// Circular FIFO that buffers timer samples for a later consumer.
// It reports occupancy and a sticky flag for samples lost while the FIFO was full.
module sample_queue #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    sample_queue_if.slave    bus
);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              overflow_r;

    logic              full_s;
    logic              empty_s;
    logic              deq_ok_s;
    logic              enq_ok_s;
    logic              drop_s;

    // Decode flags from the registered count and evaluate acceptance terms.
    always_comb begin
        full_s   = (count_r == FULL_COUNT);
        empty_s  = (count_r == '0);
        deq_ok_s = bus.deq_en & ~empty_s;
        // A full FIFO can still take a sample when the same edge frees a slot.
        enq_ok_s = bus.in_valid & (~full_s | deq_ok_s);
        drop_s   = bus.in_valid & ~enq_ok_s;
    end

    // Sample storage; never reset, since stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (enq_ok_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy, popped data and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            overflow_r  <= 1'b0;
        end else begin
            if (enq_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (deq_ok_s) begin
                out_data_r  <= mem_r[rd_ptr_r];
                rd_ptr_r    <= rd_ptr_r + PTR_ONE;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
            case ({enq_ok_s, deq_ok_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.overflow  = overflow_r;
    assign bus.len_out   = count_r;
    assign bus.full      = full_s;
    assign bus.empty     = empty_s;
endmodule

// File: tb/tb_sample_queue.sv
// Self-checking bench for sample_queue: a scoreboard queue receives every accepted
// sample and is drained as the DUT pops entries.
module tb_sample_queue;
    logic clk;
    logic rst;

    sample_queue_if #(.DATA_W(16), .ADDR_W(3)) sq ();

    sample_queue #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic [15:0] sb[$];
    logic        m_ovf;
    logic [15:0] last_out;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus, driven at the falling edge and checked at the next one.
    task automatic step(input logic v, input logic [15:0] d, input logic deq);
        int          cnt;
        logic        deq_ok;
        logic        enq_ok;
        logic        exp_pop;
        logic [15:0] exp_val;
        cnt      = sb.size();
        sq.in_valid = v;
        sq.in_data  = d;
        sq.deq_en   = deq;
        deq_ok   = deq && (cnt != 0);
        enq_ok   = v && ((cnt != 8) || deq_ok);
        exp_pop  = 1'b0;
        exp_val  = last_out;
        @(posedge clk);
        if (v && !enq_ok) m_ovf = 1'b1;
        if (deq_ok) begin
            exp_val  = sb.pop_front();
            exp_pop  = 1'b1;
            last_out = exp_val;
        end
        if (enq_ok) sb.push_back(d);
        @(negedge clk);
        sq.in_valid = 1'b0;
        sq.deq_en   = 1'b0;
        chk("out_valid", {31'd0, sq.out_valid}, {31'd0, exp_pop});
        chk("out_data", {16'd0, sq.out_data}, {16'd0, exp_val});
        chk("len_out", {28'd0, sq.len_out}, 32'(sb.size()));
        chk("full", {31'd0, sq.full}, {31'd0, sb.size() == 8});
        chk("empty", {31'd0, sq.empty}, {31'd0, sb.size() == 0});
        chk("overflow", {31'd0, sq.overflow}, {31'd0, m_ovf});
    endtask

    // Pulse reset between edges and check that everything clears at once.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_len", {28'd0, sq.len_out}, 32'd0);
        chk("rst_empty", {31'd0, sq.empty}, 32'd1);
        chk("rst_full", {31'd0, sq.full}, 32'd0);
        chk("rst_valid", {31'd0, sq.out_valid}, 32'd0);
        chk("rst_ovf", {31'd0, sq.overflow}, 32'd0);
        chk("rst_data", {16'd0, sq.out_data}, 32'd0);
        #1;
        rst = 1'b0;
        sb.delete();
        m_ovf    = 1'b0;
        last_out = 16'd0;
        @(negedge clk);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        m_ovf       = 1'b0;
        last_out    = 16'd0;
        rst         = 1'b1;
        sq.in_valid = 1'b0;
        sq.in_data  = 16'd0;
        sq.deq_en   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("init_len", {28'd0, sq.len_out}, 32'd0);
        chk("init_empty", {31'd0, sq.empty}, 32'd1);

        // Basic write then pop.
        for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b0);
        chk("t1_len", {28'd0, sq.len_out}, 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b1);
        chk("t1_last", {16'd0, sq.out_data}, 32'h0003);
        chk("t1_empty", {31'd0, sq.empty}, 32'd1);

        // Fill, drop one, drain.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0010 + 16'(i), 1'b0);
        step(1'b1, 16'h00FF, 1'b0);
        chk("t2_ovf", {31'd0, sq.overflow}, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 16'd0, 1'b1);
        chk("t2_last", {16'd0, sq.out_data}, 32'h0017);

        // Simultaneous enqueue and dequeue while full.
        pulse_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0020 + 16'(i), 1'b0);
        step(1'b1, 16'h0AAA, 1'b1);
        chk("t3_len", {28'd0, sq.len_out}, 32'd8);
        chk("t3_ovf", {31'd0, sq.overflow}, 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 16'd0, 1'b1);
        chk("t3_last", {16'd0, sq.out_data}, 32'h0AAA);

        // Dequeue on empty, then enqueue+dequeue on empty.
        step(1'b0, 16'd0, 1'b1);
        chk("t4_hold", {16'd0, sq.out_data}, 32'h0AAA);
        step(1'b1, 16'h0055, 1'b1);
        chk("t4_len", {28'd0, sq.len_out}, 32'd1);
        step(1'b0, 16'd0, 1'b1);

        // Interleaved traffic wrapping the pointers.
        for (int i = 0; i < 20; i++) step(1'b1, 16'(i), i > 0);
        step(1'b0, 16'd0, 1'b1);
        chk("t5_last", {16'd0, sq.out_data}, 32'd19);
        chk("t5_ovf", {31'd0, sq.overflow}, 32'd0);

        // Reset in the middle of operation.
        for (int i = 0; i < 9; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b1);
        chk("t6_len", {28'd0, sq.len_out}, 32'd5);
        chk("t6_ovf", {31'd0, sq.overflow}, 32'd1);
        pulse_reset();
        step(1'b0, 16'd0, 1'b1);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_residue: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
